// File: rtl/excess3tobcd_seq_pkg.sv
// Shared definitions for the sequential Excess-3 to BCD decoder:
// FSM state encoding and the Excess-3 code range constants.
package excess3tobcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] E3Offset   = 4'd3;
  localparam logic [3:0] E3Min      = 4'd3;
  localparam logic [3:0] E3Max      = 4'd12;
  localparam logic [3:0] E3ErrDigit = 4'hF;

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/excess3tobcd_seq_digit_dec.sv
// Combinational single-digit Excess-3 to BCD decode with illegal-code flag.
module excess3tobcd_seq_digit_dec
  import excess3tobcd_seq_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  always_comb begin
    illegal_o = (code_i < E3Min) || (code_i > E3Max);
    bcd_o     = illegal_o ? E3ErrDigit : (code_i - E3Offset);
  end

endmodule

// File: rtl/excess3tobcd_seq.sv
// Multi-digit Excess-3 to BCD decoder: accepts a word, decodes one digit per
// clock (LSD first), then holds the result on a valid/ready output port.
module excess3tobcd_seq
  import excess3tobcd_seq_pkg::*;
#(
  parameter int unsigned Digits = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*Digits-1:0]   e_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*Digits-1:0]   b_out_o,
  output logic [Digits-1:0]     err_mask_o,
  output logic                  err_o
);

  localparam int unsigned W    = 4 * Digits;
  localparam int unsigned CntW = cnt_width(Digits);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      shreg_q, shreg_d;
  logic [W-1:0]      bout_q, bout_d;
  logic [Digits-1:0] mask_q, mask_d;

  logic [3:0] dig_bcd;
  logic       dig_ill;

  excess3tobcd_seq_digit_dec u_dec (
    .code_i    (shreg_q[3:0]),
    .bcd_o     (dig_bcd),
    .illegal_o (dig_ill)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bout_d  = bout_q;
    mask_d  = mask_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          shreg_d = e_in_i;
          bout_d  = '0;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        for (int k = 0; k < int'(Digits); k++) begin
          if (cnt_q == CntW'(k)) begin
            bout_d[4*k +: 4] = dig_bcd;
            mask_d[k]        = dig_ill;
          end
        end
        shreg_d = shreg_q >> 4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(Digits - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      bout_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bout_q  <= bout_d;
      mask_q  <= mask_d;
    end
  end

  // Handshake outputs decode state only; reset masks acceptance.
  assign in_ready_o  = (state_q == StIdle) && !rst_i;
  assign out_valid_o = (state_q == StDone);
  assign b_out_o     = bout_q;
  assign err_mask_o  = mask_q;
  assign err_o       = |mask_q;

endmodule

// File: tb/tb_excess3tobcd_seq.sv
// Self-checking bench for excess3tobcd_seq (4 digits): directed cases, digit
// sweep and random words checked against an arithmetic reference model.
module tb_excess3tobcd_seq;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4*D-1:0] e_in;
  logic          out_valid;
  logic          out_ready;
  logic [4*D-1:0] b_out;
  logic [D-1:0]  err_mask;
  logic          err;

  int total = 0;
  int bad   = 0;

  excess3tobcd_seq #(.Digits(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .e_in_i      (e_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .b_out_o     (b_out),
    .err_mask_o  (err_mask),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each digit decoded by plain integer arithmetic.
  task automatic model(input logic [4*D-1:0] e, output logic [4*D-1:0] b,
                       output logic [D-1:0] m);
    int code;
    b = '0;
    m = '0;
    for (int k = 0; k < D; k++) begin
      code = int'((e >> (4 * k)) & 16'hF);
      if (code >= 3 && code <= 12) begin
        b = b | ((4*D)'(code - 3) << (4 * k));
      end else begin
        b    = b | ((4*D)'(15) << (4 * k));
        m[k] = 1'b1;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Full transfer with out_ready held high; checks latency and result.
  task automatic run_word(input string tag, input logic [4*D-1:0] e,
                          input logic [4*D-1:0] exp_b, input logic [D-1:0] exp_m);
    wait_ready(tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    e_in      = e;
    step();
    in_valid  = 1'b0;
    e_in      = $urandom;
    for (int i = 0; i < D - 1; i++) begin
      step();
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_b_out"}, 32'(b_out), 32'(exp_b));
    chk({tag, "_mask"}, 32'(err_mask), 32'(exp_m));
    chk({tag, "_err"}, 32'(err), 32'(exp_m != '0));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_model(input string tag, input logic [4*D-1:0] e);
    logic [4*D-1:0] b;
    logic [D-1:0]   m;
    model(e, b, m);
    run_word(tag, e, b, m);
  endtask

  initial begin
    logic [4*D-1:0] w;
    logic [3:0]     filler;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e_in      = '0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_mask", 32'(err_mask), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_word("w3456", 16'h3456, 16'h0123, 4'b0000);
    run_word("wCCCC", 16'hCCCC, 16'h9999, 4'b0000);
    run_word("w3333", 16'h3333, 16'h0000, 4'b0000);
    run_word("w3A1B", 16'h3A1B, 16'h07F8, 4'b0010);

    // Back-pressure: hold result for 5 cycles while a new word is offered.
    wait_ready("bp");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    e_in      = 16'h5678;
    step();
    in_valid  = 1'b0;
    for (int i = 0; i < D; i++) step();
    in_valid = 1'b1;
    e_in     = 16'hCCCC;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_b_out", 32'(b_out), 32'h2345);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_valid_last", 32'(out_valid), 32'd1);
    step();
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_after_ready", 32'(in_ready), 32'd1);
    chk("bp_b_kept", 32'(b_out), 32'h2345);

    // Asynchronous reset part-way through conversion.
    in_valid = 1'b1;
    e_in     = 16'h3456;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_b_out", 32'(b_out), 32'd0);
    chk("mid_rst_mask", 32'(err_mask), 32'd0);
    step();
    rst = 1'b0;
    #1;
    run_word("w4444", 16'h4444, 16'h1111, 4'b0000);

    // Every code in every position, other digits random legal codes.
    for (int pos = 0; pos < D; pos++) begin
      for (int code = 0; code < 16; code++) begin
        w = '0;
        for (int k = 0; k < D; k++) begin
          filler = 4'($urandom_range(3, 12));
          w = w | ((4*D)'(filler) << (4 * k));
        end
        w = w & ~((4*D)'(16'hF) << (4 * pos));
        w = w | ((4*D)'(code) << (4 * pos));
        run_model($sformatf("sweep_p%0d_c%0d", pos, code), w);
      end
    end

    for (int i = 0; i < 40; i++) begin
      w = (4*D)'($urandom);
      run_model($sformatf("rand%0d", i), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
